// File: rtl/data_memory_ctrl_if.sv
// Bus between the dual-processor arbiter (master) and the data memory responder (slave).
// It carries one shared read channel and one shared write channel.
interface data_memory_ctrl_if #(
  parameter int DOUBLEWORD_WIDTH = 64,
  parameter int ADDR_WIDTH_DM    = 8,
  parameter int DATA_TYPE_WIDTH  = 2
);
  logic [DOUBLEWORD_WIDTH-1:0] data_bus_rd;
  logic [ADDR_WIDTH_DM-1:0]    addr_rd;
  logic [DATA_TYPE_WIDTH-1:0]  data_type_rd;
  logic                        rd_ins;
  logic                        rd_idle;
  logic [DOUBLEWORD_WIDTH-1:0] data_bus_wr;
  logic [ADDR_WIDTH_DM-1:0]    addr_wr;
  logic [DATA_TYPE_WIDTH-1:0]  data_type_wr;
  logic                        wr_ins;
  logic                        wr_idle;

  modport master (
    input  data_bus_rd, rd_idle, wr_idle,
    output addr_rd, data_type_rd, rd_ins,
    output data_bus_wr, addr_wr, data_type_wr, wr_ins
  );

  modport slave (
    output data_bus_rd, rd_idle, wr_idle,
    input  addr_rd, data_type_rd, rd_ins,
    input  data_bus_wr, addr_wr, data_type_wr, wr_ins
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-wide data memory with independent read and write engines.
// Each engine moves one byte per clock and assembles or splits the data little-endian.
module data_memory_ctrl #(
  parameter int DOUBLEWORD_WIDTH = 64,
  parameter int DATA_MEMORY_SIZE = 256,
  parameter int ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE),
  parameter int DATA_TYPE_WIDTH  = 2
) (
  input logic               clk,
  input logic               rst_n,
  data_memory_ctrl_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [ADDR_WIDTH_DM:0] MEM_SIZE = (ADDR_WIDTH_DM+1)'(DATA_MEMORY_SIZE);

  // Index of the final byte: 0, 1, 3 or 7 for byte, halfword, word or doubleword.
  function automatic logic [2:0] last_idx(input logic [DATA_TYPE_WIDTH-1:0] t);
    return 3'((4'd1 << t) - 4'd1);
  endfunction

  function automatic logic [ADDR_WIDTH_DM-1:0] wrap_add(input logic [ADDR_WIDTH_DM-1:0] base,
                                                       input logic [2:0] off);
    logic [ADDR_WIDTH_DM:0] sum;
    sum = {1'b0, base} + (ADDR_WIDTH_DM+1)'(off);
    if (sum >= MEM_SIZE) sum = sum - MEM_SIZE;
    return sum[ADDR_WIDTH_DM-1:0];
  endfunction

  logic [7:0] mem [DATA_MEMORY_SIZE];

  state_t                      rd_state_q, rd_state_d;
  logic [2:0]                  rd_i_q, rd_i_d;
  logic [ADDR_WIDTH_DM-1:0]    rd_addr_q, rd_addr_d;
  logic [DATA_TYPE_WIDTH-1:0]  rd_type_q, rd_type_d;
  logic [DOUBLEWORD_WIDTH-1:0] rd_asm_q, rd_asm_d;
  logic [DOUBLEWORD_WIDTH-1:0] data_rd_q, data_rd_d;
  logic [DOUBLEWORD_WIDTH-1:0] rd_merged;
  logic [ADDR_WIDTH_DM-1:0]    rd_ptr;
  logic [7:0]                  rd_byte;

  state_t                      wr_state_q, wr_state_d;
  logic [2:0]                  wr_i_q, wr_i_d;
  logic [ADDR_WIDTH_DM-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_TYPE_WIDTH-1:0]  wr_type_q, wr_type_d;
  logic [DOUBLEWORD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH_DM-1:0]    wr_ptr;
  logic [7:0]                  wr_byte;

  assign rd_ptr  = wrap_add(rd_addr_q, rd_i_q);
  assign wr_ptr  = wrap_add(wr_addr_q, wr_i_q);
  assign rd_byte = mem[rd_ptr];
  assign wr_byte = wr_data_q[{wr_i_q, 3'b000} +: 8];

  // Read engine
  always_comb begin
    rd_state_d = rd_state_q;
    rd_i_d     = rd_i_q;
    rd_addr_d  = rd_addr_q;
    rd_type_d  = rd_type_q;
    rd_asm_d   = rd_asm_q;
    data_rd_d  = data_rd_q;
    rd_merged  = rd_asm_q | (DOUBLEWORD_WIDTH'(rd_byte) << {rd_i_q, 3'b000});
    case (rd_state_q)
      IDLE: begin
        if (bus.rd_ins) begin
          rd_state_d = BUSY;
          rd_addr_d  = bus.addr_rd;
          rd_type_d  = bus.data_type_rd;
          rd_i_d     = '0;
          rd_asm_d   = '0;
        end
      end
      BUSY: begin
        rd_asm_d = rd_merged;
        rd_i_d   = rd_i_q + 3'd1;
        if (rd_i_q == last_idx(rd_type_q)) begin
          rd_state_d = IDLE;
          rd_i_d     = '0;
          data_rd_d  = rd_merged;
        end
      end
      default: rd_state_d = IDLE;
    endcase
  end

  // Write engine
  always_comb begin
    wr_state_d = wr_state_q;
    wr_i_d     = wr_i_q;
    wr_addr_d  = wr_addr_q;
    wr_type_d  = wr_type_q;
    wr_data_d  = wr_data_q;
    case (wr_state_q)
      IDLE: begin
        if (bus.wr_ins) begin
          wr_state_d = BUSY;
          wr_addr_d  = bus.addr_wr;
          wr_type_d  = bus.data_type_wr;
          wr_data_d  = bus.data_bus_wr;
          wr_i_d     = '0;
        end
      end
      BUSY: begin
        wr_i_d = wr_i_q + 3'd1;
        if (wr_i_q == last_idx(wr_type_q)) begin
          wr_state_d = IDLE;
          wr_i_d     = '0;
        end
      end
      default: wr_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= IDLE;
      rd_i_q     <= '0;
      rd_addr_q  <= '0;
      rd_type_q  <= '0;
      rd_asm_q   <= '0;
      data_rd_q  <= '0;
      wr_state_q <= IDLE;
      wr_i_q     <= '0;
      wr_addr_q  <= '0;
      wr_type_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_i_q     <= rd_i_d;
      rd_addr_q  <= rd_addr_d;
      rd_type_q  <= rd_type_d;
      rd_asm_q   <= rd_asm_d;
      data_rd_q  <= data_rd_d;
      wr_state_q <= wr_state_d;
      wr_i_q     <= wr_i_d;
      wr_addr_q  <= wr_addr_d;
      wr_type_q  <= wr_type_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Storage is never reset; the engine being forced to IDLE stops further writes.
  always_ff @(posedge clk) begin
    if (wr_state_q == BUSY) mem[wr_ptr] <= wr_byte;
  end

  assign bus.data_bus_rd = data_rd_q;
  assign bus.rd_idle     = (rd_state_q == IDLE);
  assign bus.wr_idle     = (wr_state_q == IDLE);
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Byte-organised data memory responder serving the single shared read channel and the single shared write channel that the two-processor arbiter drives. It accepts one read request and one write request independently, moves one byte per clock on each channel, and signals completion through `rd_idle` / `wr_idle`. Data is assembled and split little-endian for byte, halfword, word and doubleword accesses. The block sits directly below the arbiter and is the only owner of the data storage array.

## Interface
Parameters:
- DOUBLEWORD_WIDTH, 64: width of the read and write data buses.
- DATA_MEMORY_SIZE, 256: storage size in bytes.
- ADDR_WIDTH_DM, $clog2(DATA_MEMORY_SIZE): byte address width.
- DATA_TYPE_WIDTH, 2: access-size field width. Encoding: 0 = byte, 1 = halfword, 2 = word, 3 = doubleword.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_bus_rd  out  DOUBLEWORD_WIDTH  read result, zero-extended.
- addr_rd  in  ADDR_WIDTH_DM  read start byte address.
- data_type_rd  in  DATA_TYPE_WIDTH  read size.
- rd_ins  in  1  read request.
- rd_idle  out  1  read engine free; result valid.
- data_bus_wr  in  DOUBLEWORD_WIDTH  write data, with the low bytes used.
- addr_wr  in  ADDR_WIDTH_DM  write start byte address.
- data_type_wr  in  DATA_TYPE_WIDTH  write size.
- wr_ins  in  1  write request.
- wr_idle  out  1  write engine free.

## Operation
- Storage: DATA_MEMORY_SIZE x 8-bit array. It has one byte read port and one byte write port. Contents are not affected by reset.
- Byte count: n = 1, 2, 4, 8 for type 0, 1, 2, 3.
- Each engine has two states, IDLE and BUSY, and a 3-bit byte counter `i`. The read and write engines are fully independent and may be busy at the same time.
- Read engine, IDLE -> BUSY: taken on an edge where `rd_ins = 1` and `rd_idle = 1`. The engine latches `addr_rd` and `data_type_rd`, clears `i`, and clears an internal assembly register.
- Read engine, in BUSY: each edge reads the byte at (addr + i) mod DATA_MEMORY_SIZE into assembly bits [8i+7:8i], then increments `i`.
- Read engine, BUSY -> IDLE: on the edge that reads byte n-1. On that edge `data_bus_rd` loads the complete assembly value. Bytes at index n and above are 0.
- `data_bus_rd` is a register. It changes only on a read-completion edge and holds its value otherwise.
- Write engine, IDLE -> BUSY: taken on an edge where `wr_ins = 1` and `wr_idle = 1`. The engine latches `addr_wr`, `data_type_wr` and `data_bus_wr`.
- Write engine, in BUSY: each edge writes latched data byte i to (addr + i) mod DATA_MEMORY_SIZE.
- Write engine, BUSY -> IDLE: after byte n-1 is written.
- `rd_ins` or `wr_ins` asserted while the matching engine is BUSY is ignored. Changes to addr, type or data inputs during BUSY have no effect.
- Wrap-around: addresses are incremented modulo DATA_MEMORY_SIZE. Misaligned addresses are legal.
- Same byte read and written on the same edge: the read returns the old value (read-before-write).
- Reset asserted mid-operation: the access is aborted immediately. Any bytes already written remain in the array.

## Timing
- Reset values: `rd_idle = 1`, `wr_idle = 1`, `data_bus_rd = 0`. Both states return to IDLE and `i = 0`.
- Let the request be accepted at edge E0. Then:
  - `rd_idle` / `wr_idle` is 0 from E0 through En, where the final byte is transferred at edge En.
  - The idle output returns to 1 after En.
  - `data_bus_rd` is valid after En.
- Latency is n clock cycles with the idle output low.
- Idle outputs are registered, with no combinational path from `rd_ins` or `wr_ins`.
- Back-to-back accesses: the earliest next acceptance is edge En+1. Throughput is one byte per cycle per channel.

## Test plan
- Doubleword write then read: write 0x0123456789ABCDEF to addr 0x10, type 3 -> `wr_idle` low for 8 cycles. Read addr 0x10, type 3 -> `rd_idle` low for 8 cycles, then `data_bus_rd` = 0x0123456789ABCDEF.
- Size and zero-extension: with the same contents, read addr 0x10 with types 0, 1 and 2 -> results 0xEF, 0xCDEF and 0x89ABCDEF, upper bits 0. Read addr 0x13, type 1 (misaligned) -> 0x6789.
- Wrap-around: write word 0xAABBCCDD at addr 254 -> bytes 254 = 0xDD, 255 = 0xCC, 0 = 0xBB, 1 = 0xAA. Reading a word at 254 returns 0xAABBCCDD.
- Concurrent read and write: start a read of the word at 0x20 (old value 0x11111111) and, on the same edge, a write of 0x22222222 to 0x20 -> read returns 0x11111111. A read started afterwards returns 0x22222222.
- Request while busy: pulse `rd_ins` with addr 0x40 during a doubleword read of 0x10 -> ignored. `rd_idle` stays low exactly 8 cycles and the result is the 0x10 data.
- Reset mid-write: write doubleword 0xFFFFFFFFFFFFFFFF to 0x30, assert `rst_n` low after 3 bytes -> `wr_idle = 1` and `data_bus_rd = 0` immediately. After reset, a doubleword read of 0x30 shows only bytes 0x30–0x32 = 0xFF.
